// File: rtl/mux_scan_sequencer.sv
// Round-robin channel scanner for a 4-to-1 mux.
//
// Walks the enabled channels A..D (ascending, wrapping 3->0) by driving the mux
// select lines. Each channel's select is held for SETTLE fixed cycles plus a
// programmable dwell, then the mux output is registered and tagged with its
// channel. The channel mask, dwell and single-pass mode are latched when a
// scan starts; later changes on those inputs wait for the next start.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start_i        begin a scan (sampled only while idle)
//   stop_i         abort a scan at the next edge (beats start_i)
//   single_i       1 = one pass then idle, 0 = continuous (latched at start)
//   ch_mask_i      channel enables, bit0=A .. bit3=D (latched at start)
//   dwell_i        dwell cycles per channel (latched at start)
//   mux_out_i      OUT of the 4-to-1 mux
//   s1_o, s2_o     mux select, {s1_o,s2_o} = channel index
//   sample_o       captured mux output
//   sample_ch_o    channel of sample_o, {S1,S2} encoding
//   sample_valid_o one-cycle strobe, sample_o/sample_ch_o valid
//   pass_done_o    one-cycle strobe, capture that wraps to the lowest channel
//   busy_o         high while a scan is in progress

module mux_scan_sequencer #(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               single_i,
  input  logic [3:0]         ch_mask_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               mux_out_i,
  output logic               s1_o,
  output logic               s2_o,
  output logic               sample_o,
  output logic [1:0]         sample_ch_o,
  output logic               sample_valid_o,
  output logic               pass_done_o,
  output logic               busy_o
);

  // One down-counter serves both the settle and the dwell phase, so it is
  // as wide as the larger of the two.
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned CntW = (DWELL_W > SetW) ? DWELL_W : SetW;
  localparam logic [CntW-1:0] SettleLoad = (SETTLE > 0) ? CntW'(SETTLE - 1) : '0;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StDwell,
    StCapture
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               single_q, single_d;
  logic               sample_q, sample_d;
  logic [1:0]         sample_ch_q, sample_ch_d;
  logic               sample_valid_q, sample_valid_d;
  logic               pass_done_q, pass_done_d;
  logic               busy_q, busy_d;
  logic [1:0]         next_sel;
  logic               wraps;

  // Lowest enabled channel of a mask (0 if the mask is empty).
  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) res = 2'(i);
    end
    return res;
  endfunction

  // Next enabled channel above cur, wrapping 3->0. A lone enabled channel
  // selects itself again.
  function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] res;
    logic [1:0] idx;
    res = cur;
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) res = idx;
    end
    return res;
  endfunction

  // Counter load for a dwell phase of dv cycles (dv != 0).
  function automatic logic [CntW-1:0] dwell_load(input logic [DWELL_W-1:0] dv);
    return CntW'(dv) - CntW'(1);
  endfunction

  // First phase of a fresh select window; empty phases are skipped.
  function automatic state_e first_phase(input logic [DWELL_W-1:0] dv);
    if (SETTLE > 0) return StSettle;
    if (dv != '0) return StDwell;
    return StCapture;
  endfunction

  function automatic logic [CntW-1:0] first_load(input logic [DWELL_W-1:0] dv);
    if (SETTLE > 0) return SettleLoad;
    if (dv != '0) return dwell_load(dv);
    return '0;
  endfunction

  assign next_sel = next_ch(sel_q, mask_q);
  assign wraps    = (next_sel == lowest_ch(mask_q));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sel_d          = sel_q;
    mask_d         = mask_q;
    dwell_d        = dwell_q;
    single_d       = single_q;
    sample_d       = sample_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = 1'b0;
    pass_done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // stop beats start; an empty mask never starts a scan.
        if (start_i && !stop_i && (ch_mask_i != 4'b0000)) begin
          mask_d   = ch_mask_i;
          dwell_d  = dwell_i;
          single_d = single_i;
          sel_d    = lowest_ch(ch_mask_i);
          state_d  = first_phase(dwell_i);
          cnt_d    = first_load(dwell_i);
        end
      end

      StSettle: begin
        if (stop_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          if (dwell_q != '0) begin
            state_d = StDwell;
            cnt_d   = dwell_load(dwell_q);
          end else begin
            state_d = StCapture;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StDwell: begin
        if (stop_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StCapture: begin
        if (stop_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          sample_d       = mux_out_i;
          sample_ch_d    = sel_q;
          sample_valid_d = 1'b1;
          pass_done_d    = wraps;
          if (wraps && single_q) begin
            // End of a single pass: the select stays on the captured channel.
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            sel_d   = next_sel;
            state_d = first_phase(dwell_q);
            cnt_d   = first_load(dwell_q);
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      sel_q          <= 2'd0;
      mask_q         <= 4'b0000;
      dwell_q        <= '0;
      single_q       <= 1'b0;
      sample_q       <= 1'b0;
      sample_ch_q    <= 2'd0;
      sample_valid_q <= 1'b0;
      pass_done_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sel_q          <= sel_d;
      mask_q         <= mask_d;
      dwell_q        <= dwell_d;
      single_q       <= single_d;
      sample_q       <= sample_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      pass_done_q    <= pass_done_d;
      busy_q         <= busy_d;
    end
  end

  assign s1_o           = sel_q[1];
  assign s2_o           = sel_q[0];
  assign sample_o       = sample_q;
  assign sample_ch_o    = sample_ch_q;
  assign sample_valid_o = sample_valid_q;
  assign pass_done_o    = pass_done_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a mux model closes the loop from the selects
// to mux_out, a window-countdown reference model is compared every cycle, and
// table-driven and hand-written scans check latency, order and corner cases.

module tb_mux_scan_sequencer;

  localparam int SETTLE  = 1;
  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start, stop, single;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         pat;
  logic               mux_out;
  logic               s1, s2, sample, sample_valid, pass_done, busy;
  logic [1:0]         sample_ch;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign mux_out = pat[{s1, s2}];

  mux_scan_sequencer #(
    .DWELL_W (DWELL_W),
    .SETTLE  (SETTLE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .stop_i         (stop),
    .single_i       (single),
    .ch_mask_i      (mask),
    .dwell_i        (dwell),
    .mux_out_i      (mux_out),
    .s1_o           (s1),
    .s2_o           (s2),
    .sample_o       (sample),
    .sample_ch_o    (sample_ch),
    .sample_valid_o (sample_valid),
    .pass_done_o    (pass_done),
    .busy_o         (busy)
  );

  // ---------------- reference model ----------------
  // A scan is a busy flag, the selected channel and the number of cycles left
  // in its select window; the capture happens when the window runs out.
  typedef struct {
    bit       busy;
    int       ch;
    int       rem;
    bit [3:0] mask;
    int       dwell;
    bit       single;
    bit       sample;
    int       sample_ch;
    bit       sv;
    bit       pd;
  } mstate_t;

  mstate_t m;

  function automatic int lowest(input bit [3:0] mk);
    for (int i = 0; i < 4; i++) if (mk[i]) return i;
    return 0;
  endfunction

  function automatic int next_en(input int c, input bit [3:0] mk);
    for (int k = 1; k <= 4; k++) if (mk[(c + k) % 4]) return (c + k) % 4;
    return c;
  endfunction

  function automatic mstate_t model_reset();
    mstate_t r;
    r.busy = 0; r.ch = 0; r.rem = 0; r.mask = 0; r.dwell = 0; r.single = 0;
    r.sample = 0; r.sample_ch = 0; r.sv = 0; r.pd = 0;
    return r;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input bit st, input bit sp,
                                         input bit sg, input bit [3:0] mk, input int dw,
                                         input bit [3:0] pt);
    mstate_t n;
    int nx;
    n = s;
    n.sv = 0;
    n.pd = 0;
    if (!s.busy) begin
      if (st && !sp && mk != 0) begin
        n.busy = 1; n.mask = mk; n.dwell = dw; n.single = sg;
        n.ch = lowest(mk);
        n.rem = SETTLE + dw + 1;
      end
    end else if (sp) begin
      n.busy = 0;
    end else begin
      n.rem = s.rem - 1;
      if (n.rem == 0) begin
        n.sv = 1;
        n.sample = pt[s.ch];
        n.sample_ch = s.ch;
        nx = next_en(s.ch, s.mask);
        n.pd = (nx == lowest(s.mask));
        if (n.pd && s.single) begin
          n.busy = 0;
        end else begin
          n.ch = nx;
          n.rem = SETTLE + s.dwell + 1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, start, stop, single, mask, int'(dwell), pat);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock; outputs are compared with the model 1 time unit after the edge.
  task automatic tick();
    logic [7:0] act, exp;
    @(posedge clk);
    #1;
    if (rst_n) begin
      act = {s1, s2, sample, sample_ch, sample_valid, pass_done, busy};
      exp = {2'(m.ch), m.sample, 2'(m.sample_ch), m.sv, m.pd, m.busy};
      check("model", 32'(act), 32'(exp));
    end
  endtask

  int got_ch[8];
  int got_pd[8];
  int got_sel[8];
  int got_t[8];

  task automatic collect(input int n, input int bound);
    int cnt = 0;
    int t = 0;
    while (cnt < n && t < bound) begin
      tick();
      t++;
      if (sample_valid) begin
        got_ch[cnt] = int'(sample_ch);
        got_pd[cnt] = int'(pass_done);
        got_sel[cnt] = int'({s1, s2});
        got_t[cnt] = t;
        cnt++;
      end
    end
    check("collect_count", 32'(cnt), 32'(n));
  endtask

  task automatic stop_scan();
    stop = 1;
    tick();
    stop = 0;
    check("stopped_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- single-pass vector table ----------------
  typedef struct {
    logic [3:0] mask;
    logic [7:0] dwell;
    logic       single;
    logic [3:0] pat;
    int         exp_lat;
    logic [1:0] exp_ch;
    logic       exp_sample;
    int         exp_strobes;
    logic [1:0] exp_final;
  } vec_t;

  vec_t tv[7];

  initial begin
    int lat, nstr, guard;

    tv[0] = '{4'b1111, 8'd2,   1'b1, 4'b1010, 4,   2'd0, 1'b0, 4, 2'd3};
    tv[1] = '{4'b1010, 8'd0,   1'b1, 4'b1111, 2,   2'd1, 1'b1, 2, 2'd3};
    tv[2] = '{4'b0100, 8'd1,   1'b1, 4'b0100, 3,   2'd2, 1'b1, 1, 2'd2};
    tv[3] = '{4'b0001, 8'd3,   1'b1, 4'b0000, 5,   2'd0, 1'b0, 1, 2'd0};
    tv[4] = '{4'b1001, 8'd5,   1'b1, 4'b1000, 7,   2'd0, 1'b0, 2, 2'd3};
    tv[5] = '{4'b0110, 8'd0,   1'b1, 4'b0110, 2,   2'd1, 1'b1, 2, 2'd2};
    tv[6] = '{4'b1000, 8'd255, 1'b1, 4'b1000, 257, 2'd3, 1'b1, 1, 2'd3};

    start = 0; stop = 0; single = 0; mask = 0; dwell = 0; pat = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel", 32'({s1, s2}), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_sample_ch", 32'(sample_ch), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_pass_done", 32'(pass_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 7; i++) begin
      mask = tv[i].mask; dwell = tv[i].dwell; single = tv[i].single; pat = tv[i].pat;
      start = 1;
      tick();
      start = 0;
      check("start_busy", 32'(busy), 32'd1);
      lat = 0;
      while (!sample_valid && lat < 400) begin
        tick();
        lat++;
      end
      check("first_latency", 32'(lat), 32'(tv[i].exp_lat));
      check("first_ch", 32'(sample_ch), 32'(tv[i].exp_ch));
      check("first_sample", 32'(sample), 32'(tv[i].exp_sample));
      nstr = 1;
      guard = 0;
      while (busy && guard < 2000) begin
        tick();
        guard++;
        if (sample_valid) nstr++;
      end
      check("pass_strobes", 32'(nstr), 32'(tv[i].exp_strobes));
      check("final_sel", 32'({s1, s2}), 32'(tv[i].exp_final));
      check("last_pass_done", 32'(pass_done), 32'd1);
      check("last_valid", 32'(sample_valid), 32'd1);
      tick();
      tick();
    end

    // Continuous scan of B and D with no dwell: strobes every 2 cycles.
    mask = 4'b1010; dwell = 0; single = 0; pat = 4'b1111;
    start = 1;
    tick();
    start = 0;
    collect(6, 40);
    for (int i = 0; i < 6; i++) begin
      check("alt_ch", 32'(got_ch[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
      check("alt_pd", 32'(got_pd[i]), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i > 0) check("alt_spacing", 32'(got_t[i] - got_t[i-1]), 32'd2);
    end
    stop_scan();
    tick();

    // Abort during the dwell of channel C.
    mask = 4'b1111; dwell = 2; single = 0; pat = 4'b1010;
    start = 1;
    tick();
    start = 0;
    repeat (9) tick();
    check("abort_pre_sel", 32'({s1, s2}), 32'd2);
    check("abort_pre_busy", 32'(busy), 32'd1);
    stop = 1;
    tick();
    stop = 0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sel", 32'({s1, s2}), 32'd2);
    check("abort_valid", 32'(sample_valid), 32'd0);
    check("abort_pd", 32'(pass_done), 32'd0);
    repeat (6) begin
      tick();
      check("abort_quiet", 32'(sample_valid), 32'd0);
    end

    // stop and start together while idle.
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    check("stop_start_busy", 32'(busy), 32'd0);
    tick();
    check("stop_start_busy2", 32'(busy), 32'd0);

    // Empty mask never starts.
    mask = 4'b0000; start = 1;
    tick();
    start = 0;
    check("empty_mask_busy", 32'(busy), 32'd0);
    repeat (5) tick();

    // Lone channel C, continuous: every capture ends a pass.
    mask = 4'b0100; dwell = 1; single = 0; pat = 4'b0100;
    start = 1;
    tick();
    start = 0;
    collect(4, 40);
    for (int i = 0; i < 4; i++) begin
      check("lone_ch", 32'(got_ch[i]), 32'd2);
      check("lone_pd", 32'(got_pd[i]), 32'd1);
      check("lone_sel", 32'(got_sel[i]), 32'd2);
      if (i > 0) check("lone_spacing", 32'(got_t[i] - got_t[i-1]), 32'd3);
    end
    stop_scan();
    tick();

    // Asynchronous reset while in the settle phase.
    mask = 4'b1111; dwell = 2; single = 0; pat = 4'b1111;
    start = 1;
    tick();
    start = 0;
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 0;
    #1;
    check("async_rst_outputs", 32'({s1, s2, sample, sample_ch, sample_valid, pass_done, busy}),
          32'd0);
    tick();
    rst_n = 1;
    tick();
    mask = 4'b0001; dwell = 2; single = 1; pat = 4'b0001;
    start = 1;
    tick();
    start = 0;
    lat = 0;
    while (!sample_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_ch", 32'(sample_ch), 32'd0);
    check("post_rst_sample", 32'(sample), 32'd1);
    repeat (3) tick();

    // Input changes while busy are ignored until the next start.
    mask = 4'b1111; dwell = 2; single = 0; pat = 4'b0110;
    start = 1;
    tick();
    start = 0;
    dwell = 5; mask = 4'b0011; single = 1;
    collect(6, 60);
    for (int i = 0; i < 6; i++) begin
      check("ignore_ch", 32'(got_ch[i]), 32'(i % 4));
      if (i > 0) check("ignore_spacing", 32'(got_t[i] - got_t[i-1]), 32'd4);
    end
    check("ignore_pd", 32'(got_pd[3]), 32'd1);
    stop_scan();
    tick();

    // Random control traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      start  = ($urandom % 4) == 0;
      stop   = ($urandom % 40) == 0;
      mask   = 4'($urandom);
      dwell  = 8'($urandom % 4);
      single = 1'($urandom);
      pat    = 4'($urandom);
      tick();
    end
    start = 0; stop = 0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
